// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;
  localparam int   CNT_W   = 4;
endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker: round-robin on ties, or fixed D priority
// when prio_mode_i is set. req_i[0] is the I requester, req_i[1] is D.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  input  logic       prio_mode_i,
  output logic [1:0] gnt_o,
  output logic       winner_o
);
  always_comb begin
    winner_o = OWNER_I;
    if (req_i == 2'b11)
      winner_o = prio_mode_i ? OWNER_D : ~last_owner_i;
    else if (req_i[1])
      winner_o = OWNER_D;
    gnt_o = 2'b00;
    if (|req_i) gnt_o = (winner_o == OWNER_D) ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (I) and load/store (D).
// Build option: define MEM_ARB_DATA_PRIORITY_EN to make D win every tie.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_sel,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    i_rdata_q, d_rdata_q;
  logic             i_rvalid_q, d_rvalid_q;
  logic [1:0]       pick_gnt;
  logic             pick_win;
  logic             prio_mode;
  logic             take;
  logic             rd_done;

`ifdef MEM_ARB_DATA_PRIORITY_EN
  assign prio_mode = 1'b1;
`else
  assign prio_mode = 1'b0;
`endif

  arb_pick2 u_pick (
    .req_i       ({d_req, i_req}),
    .last_owner_i(last_owner_q),
    .prio_mode_i (prio_mode),
    .gnt_o       (pick_gnt),
    .winner_o    (pick_win)
  );

  // Grants are Mealy and forced low while reset is asserted.
  assign take    = (state_q == IDLE) && reset && (|pick_gnt);
  assign i_gnt   = take & pick_gnt[0];
  assign d_gnt   = take & pick_gnt[1];
  assign rd_done = (state_q == WAIT) && (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: if (take) begin
        owner_d      = pick_win;
        last_owner_d = pick_win;
        we_d         = (pick_win == OWNER_D) && d_we;
        addr_d       = (pick_win == OWNER_D) ? d_addr : i_addr;
        wdata_d      = (pick_win == OWNER_D) ? d_wdata : wdata_q;
        state_d      = ACCESS;
      end
      ACCESS: if (we_q) begin
        state_d = IDLE;
      end else begin
        cnt_d   = CNT_W'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_I;
      last_owner_q <= OWNER_D;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      i_rvalid_q   <= rd_done && (owner_q == OWNER_I);
      d_rvalid_q   <= rd_done && (owner_q == OWNER_D);
      if (rd_done && owner_q == OWNER_I) i_rdata_q <= mem_rdata;
      if (rd_done && owner_q == OWNER_D) d_rdata_q <= mem_rdata;
    end
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_sel   = owner_q;
  assign busy      = (state_q != IDLE);
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int NC  = 4096;
`ifdef MEM_ARB_DATA_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, mem_sel, busy;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .busy(busy)
  );

  int npass = 0, ntot = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
  endtask

  function automatic logic [31:0] minit(int k);
    return (k == 64) ? 32'hDEADBEEF : ((32'(k) * 32'h9E3779B1) ^ 32'h5A5A0F0F);
  endfunction

  function automatic logic [AW-1:0] raddr();
    return AW'($urandom_range(0, 255)) << 2;
  endfunction

  // Memory environment: writes on mem_en&mem_we, read data valid LAT cycles after mem_en.
  logic [DW-1:0] emem [256];
  logic [DW-1:0] rdp [1:LAT];
  assign mem_rdata = rdp[LAT];
  initial begin
    for (int k = 0; k < 256; k++) emem[k] <= minit(k);
    for (int k = 1; k <= LAT; k++) rdp[k] <= '0;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) emem[mem_addr[9:2]] <= mem_wdata;
      rdp[1] <= (mem_en && !mem_we) ? emem[mem_addr[9:2]] : DW'($urandom);
      for (int k = 2; k <= LAT; k++) rdp[k] <= rdp[k-1];
    end
  end

  // Reference model: each grant books its future cycles in per-cycle expectation tables.
  logic [DW-1:0] mm [256];
  logic e_en[NC], e_we[NC], e_busy[NC], e_sel[NC], e_iv[NC], e_dv[NC];
  logic [AW-1:0] e_addr[NC];
  logic [DW-1:0] e_wd[NC], e_rd[NC];
  initial begin
    logic last_m, w, we;
    logic [1:0] eg;
    logic [AW-1:0] a;
    logic [DW-1:0] hi, hd;
    int free_c, occ;
    last_m = 1'b1; free_c = 0; hi = '0; hd = '0;
    for (int k = 0; k < 256; k++) mm[k] = minit(k);
    for (int k = 0; k < NC; k++) begin
      e_en[k] = 0; e_we[k] = 0; e_busy[k] = 0; e_sel[k] = 0; e_iv[k] = 0; e_dv[k] = 0;
      e_addr[k] = '0; e_wd[k] = '0; e_rd[k] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        last_m = 1'b1; free_c = 0; hi = '0; hd = '0;
        for (int k = cyc; k < cyc + LAT + 5 && k < NC; k++) begin
          e_en[k] = 0; e_busy[k] = 0; e_iv[k] = 0; e_dv[k] = 0;
        end
        chk("rst_busy", busy, 0);
        chk("rst_en", mem_en, 0);
        chk("rst_sel", mem_sel, 0);
        chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        chk("rst_gnt", {d_gnt, i_gnt}, 0);
      end else begin
        eg = 2'b00;
        if (cyc >= free_c && (i_req || d_req)) begin
          if (i_req && d_req) w = PRIO ? 1'b1 : !last_m;
          else                w = d_req;
          eg  = w ? 2'b10 : 2'b01;
          a   = w ? d_addr : i_addr;
          we  = w && d_we;
          occ = we ? 2 : LAT + 2;
          for (int k = 1; k < occ; k++) begin e_busy[cyc+k] = 1; e_sel[cyc+k] = w; end
          e_en[cyc+1] = 1; e_we[cyc+1] = we; e_addr[cyc+1] = a; e_wd[cyc+1] = d_wdata;
          if (we) mm[a[9:2]] = d_wdata;
          else begin
            if (w) e_dv[cyc+LAT+2] = 1; else e_iv[cyc+LAT+2] = 1;
            e_rd[cyc+LAT+2] = mm[a[9:2]];
          end
          free_c = cyc + occ;
          last_m = w;
        end
        chk("gnt", {d_gnt, i_gnt}, eg);
        chk("busy", busy, e_busy[cyc]);
        chk("mem_en", mem_en, e_en[cyc]);
        if (e_en[cyc]) begin
          chk("mem_we", mem_we, e_we[cyc]);
          chk("mem_addr", mem_addr, e_addr[cyc]);
          if (e_we[cyc]) chk("mem_wdata", mem_wdata, e_wd[cyc]);
        end
        if (e_busy[cyc]) chk("mem_sel", mem_sel, e_sel[cyc]);
        chk("rvalid", {i_rvalid, d_rvalid}, {e_iv[cyc], e_dv[cyc]});
        if (e_iv[cyc]) hi = e_rd[cyc];
        if (e_dv[cyc]) hd = e_rd[cyc];
        chk("i_rdata", i_rdata, hi);
        chk("d_rdata", d_rdata, hd);
        chk("no_x", $isunknown({mem_addr, mem_wdata}), 0);
      end
    end
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  initial begin
    logic ig, dg;
    int ng, gc[4], gw[4], c;
    repeat (3) smp();
    nxt(); reset = 1'b1;

    // I read of 0x100 alone
    nxt(); i_req = 1; i_addr = 32'h100;
    smp(); chk("A_gnt", {d_gnt, i_gnt}, 2'b01);
    nxt(); i_req = 0;
    smp(); chk("A_en_sel", {mem_en, mem_sel}, 2'b10); chk("A_addr", mem_addr, 32'h100);
    smp(); chk("A_rv_t2", i_rvalid, 0);
    smp(); chk("A_rv_t3", i_rvalid, 0);
    smp(); chk("A_rv_t4", i_rvalid, 1); chk("A_rdata", i_rdata, 32'hDEADBEEF);

    // D write 0x40
    nxt(); d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
    smp(); chk("B_gnt", {d_gnt, i_gnt}, 2'b10);
    nxt(); d_req = 0; d_we = 0;
    smp(); chk("B_cmd", {mem_en, mem_we, mem_sel}, 3'b111);
    chk("B_addr", mem_addr, 32'h40); chk("B_wdata", mem_wdata, 32'h12345678);
    smp(); chk("B_busy", busy, 0); chk("B_no_dv", d_rvalid, 0);
    repeat (3) begin smp(); chk("B_no_dv", d_rvalid, 0); end

    // Both requesting continuously
    nxt(); i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h14;
    ng = 0; c = 0;
    while (ng < 4 && c < 40) begin
      smp();
      if (i_gnt || d_gnt) begin
        gc[ng] = c; gw[ng] = d_gnt ? 1 : 0;
        if (ng > 0) chk("C_gnt_on_rvalid", i_rvalid | d_rvalid, 1);
        ng++;
      end
      nxt(); c++;
      i_addr = raddr(); d_addr = raddr();
    end
    chk("C_ngrants", ng, 4);
    for (int k = 0; k < 4 && k < ng; k++)
      chk("C_winner", gw[k], PRIO ? 1 : (k % 2));
    for (int k = 1; k < 4 && k < ng; k++)
      chk("C_spacing", gc[k] - gc[k-1], LAT + 2);
    i_req = 0; d_req = 0;
    repeat (8) nxt();

    // Async reset while a D read is waiting on memory
    d_req = 1; d_we = 0; d_addr = 32'h8;
    smp(); chk("D_gnt", d_gnt, 1);
    nxt(); d_req = 0;
    @(posedge clk); #3; reset = 1'b0;
    #1;
    chk("D_async_busy", busy, 0); chk("D_async_en", mem_en, 0);
    chk("D_async_sel", mem_sel, 0); chk("D_async_rdata", {i_rdata, d_rdata}, 0);
    chk("D_async_addr", mem_addr, 0);
    repeat (4) begin smp(); chk("D_no_dv", d_rvalid, 0); end
    nxt(); reset = 1'b1;
    i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h24;

    // Randomized traffic; first iteration sees the post-reset tie
    for (int n = 0; n < 1500; n++) begin
      smp(); ig = i_gnt; dg = d_gnt;
      if (n == 0) chk("first_tie", {d_gnt, i_gnt}, PRIO ? 2'b10 : 2'b01);
      if (n > 0 && n < 4) chk("D_no_dv_after", d_rvalid & (n < 2), 0);
      nxt();
      if (ig) i_req = 0;
      if (!i_req && $urandom_range(0, 2) != 0) begin i_req = 1; i_addr = raddr(); end
      if (dg) d_req = 0;
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = raddr(); d_wdata = $urandom;
      end
    end
    i_req = 0; d_req = 0;
    repeat (LAT + 6) nxt();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (I) and the load/store requester (D).
- Sequences each access: request accept, memory command, fixed-latency read return.
- Drives the select of the address/data 2:1 mux in front of the memory.
- Sits between the fetch/LSU logic and the memory model.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata. Legal range is 1 to 15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  I read request; held with i_addr until i_gnt.
- i_addr  in  AW  I read address.
- i_gnt  out  1  I request accepted this cycle.
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  DW  I read data.
- d_req  in  1  D request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  D address.
- d_wdata  in  DW  D write data.
- d_gnt  out  1  D request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (reads only).
- d_rdata  out  DW  D read data.
- mem_en  out  1  memory command strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  registered command address.
- mem_wdata  out  DW  registered write data.
- mem_sel  out  1  mux select, 0 = I, 1 = D; equals the current owner.
- mem_rdata  in  DW  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including rdata registers and mem_sel.
  - last_owner=D, so I wins the first tie.
  - Any in-flight read is dropped; no rvalid is produced for it.
- States:
  - IDLE:
    - If neither request is asserted, stay in IDLE.
    - Otherwise pick a winner. i_gnt/d_gnt is combinational (Mealy) and high only in IDLE, for the winner only.
    - Register the winner's addr, we and wdata, plus owner. Go to ACCESS.
    - I requests are always reads.
  - ACCESS (one cycle):
    - mem_en=1, mem_we=owner_we, mem_sel=owner.
    - Write: go to IDLE.
    - Read: load cnt=LAT-1 and go to WAIT.
  - WAIT:
    - mem_sel is held at owner; mem_en=0.
    - When cnt==0: capture mem_rdata into the owner's rdata register, set the owner's rvalid for the next cycle, and go to IDLE.
    - Otherwise decrement cnt.
- Timing, with grant in cycle T:
  - mem_en in T+1.
  - rdata sampled at the end of T+1+LAT.
  - rvalid high in T+2+LAT. State is already IDLE in that cycle, so a new grant may coincide with rvalid.
- Throughput:
  - Read occupancy is LAT+2 cycles.
  - Write occupancy is 2 cycles. Writes get no rvalid; the grant is the acknowledge.
- Arbitration:
  - One requester active: it wins.
  - Both active: round-robin; the requester that is not last_owner wins. last_owner updates on every grant.
- rdata registers hold their value between pulses. rvalid is exactly one cycle.
- Requests that arrive outside IDLE are ignored until IDLE; requesters hold them.
- mem_addr/mem_wdata are undefined-don't-care when mem_en=0 but must not be X after reset.

Optional Feature:
- Macro: MEM_ARB_DATA_PRIORITY_EN.
- Defined: fixed priority. D always wins ties; last_owner is still tracked but ignored.
- Undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum: IDLE, ACCESS, WAIT;
  - owner constants OWNER_I=1'b0, OWNER_D=1'b1;
  - the counter width constant CNT_W=4.
- One sub-module, arb_pick2: a combinational 2-way picker. Inputs: req[1:0], last_owner, prio_mode. Outputs: one-hot gnt[1:0] and winner.

Test Plan:
- LAT=2. I read 0x100 alone at T, memory returns 0xDEADBEEF → i_gnt@T, mem_en/mem_sel=0@T+1, i_rvalid=1 with i_rdata=0xDEADBEEF@T+4 only.
- D write addr 0x40 data 0x12345678 → d_gnt@T, mem_en=1/mem_we=1/mem_sel=1/mem_addr=0x40@T+1, busy=0@T+2, no d_rvalid.
- i_req and d_req held high continuously, round-robin → grants alternate I,D,I,D. Each new grant lands in the same cycle as the previous rvalid.
- Same as the previous scenario with MEM_ARB_DATA_PRIORITY_EN defined → d_gnt on every grant; i_gnt never, while d_req is high.
- reset=0 asynchronously in WAIT of a D read → all outputs 0 immediately, no d_rvalid afterwards. After release, I wins the first tie.
- LAT=1, back-to-back I reads 0x0 then 0x4 → rvalid at T+3. Second grant at T+3, its rvalid at T+6.
